// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encodings,
// the default operand width and a small state-decoding helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A new request may only be taken when no operation is in flight.
    function automatic logic can_accept(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single full-adder cell; the serial datapath pushes one operand bit pair
// through it per clock.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's complement adder/subtractor. Operands are captured on
// acceptance, then one bit per clock goes LSB-first through a single
// full-adder cell. The result outputs only update on the completion edge.
module serial_addsub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    // Holds the WIDTH-1 bits already produced; the final bit joins them
    // directly on the completion edge, so no bit of storage is wasted.
    logic [WIDTH-2:0] result;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    fa_bit u_fa (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign shifted = {fa_s, result};
    assign accept  = start && can_accept(state);
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    // Sequencer and serial datapath: accept, shift one bit per edge, publish on the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shift_a <= '0;
            shift_b <= '0;
            result  <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            state   <= ST_RUN;
            shift_a <= a;
            shift_b <= sub ? ~b : b;
            carry   <= sub;
            count   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    result  <= shifted[WIDTH-1:1];
                    carry   <= fa_cout;
                    if (count == LAST_BIT) begin
                        // Carry into the MSB is still in the flop, so overflow is formed here.
                        state <= ST_DONE;
                        sum   <= shifted;
                        cout  <= fa_cout;
                        ovf   <= carry ^ fa_cout;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a table of known vectors, random
// operations against an arithmetic reference model, and hand-written
// sequences for ignored starts, mid-run reset, back-to-back and WIDTH=16.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic reset;

    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic        start16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .sub   (sub16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one value and keep the tallies
    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: plain unsigned/signed arithmetic on w-bit operands
    function automatic void ref_model(input int w, input logic [63:0] av, input logic [63:0] bv, input bit s,
                                      output logic [63:0] es, output logic ec, output logic ev);
        longint unsigned ua, ub, modulus;
        longint sa, sb, sr, half;
        ua = av;
        ub = bv;
        modulus = 64'd1 << w;
        half = longint'(modulus / 2);
        sa = (ua >= modulus / 2) ? longint'(ua) - longint'(modulus) : longint'(ua);
        sb = (ub >= modulus / 2) ? longint'(ub) - longint'(modulus) : longint'(ub);
        if (s) begin
            es = (ua - ub) & (modulus - 1);
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            es = (ua + ub) % modulus;
            ec = ((ua + ub) >= modulus);
            sr = sa + sb;
        end
        ev = (sr >= half) || (sr < -half);
    endfunction

    // Issue one operation, scramble the operand inputs afterwards, wait (bounded) for done
    task automatic apply_stimulus(input bit wide, input logic [63:0] av, input logic [63:0] bv, input bit s,
                                  output logic [63:0] rs, output logic rc, output logic rv,
                                  output int lat, output int busy_n, output bit stable, output logic done_after);
        logic [63:0] sum_before;
        @(negedge clk);
        if (wide) begin
            a16 = av[15:0]; b16 = bv[15:0]; sub16 = s; start16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; sub8 = s; start8 = 1'b1;
        end
        sum_before = wide ? 64'(sum16) : 64'(sum8);
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        lat = 1; busy_n = 0; stable = 1'b1;
        while (!(wide ? done16 : done8) && lat < 60) begin
            if (wide ? busy16 : busy8) busy_n++;
            if ((wide ? 64'(sum16) : 64'(sum8)) !== sum_before) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        rs = wide ? 64'(sum16) : 64'(sum8);
        rc = wide ? cout16 : cout8;
        rv = wide ? ovf16 : ovf8;
        @(negedge clk);
        done_after = wide ? done16 : done8;
    endtask

    initial begin
        logic [63:0] rs, es, av, bv;
        logic rc, rv, ec, ev, done_after;
        bit s, stable;
        int lat, busy_n, dn, since, pulses, bad_gap, bad_sum;
        logic [7:0] first_sum;
        logic first_cout;

        vecs[0] = '{8'hAA, 8'hCC, 1'b0, 8'h76, 1'b1, 1'b1};
        vecs[1] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};

        reset = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check_output("reset busy", 64'(busy8), 64'd0);
        check_output("reset done", 64'(done8), 64'd0);
        check_output("reset sum", 64'(sum8), 64'd0);
        check_output("reset cout", 64'(cout8), 64'd0);
        check_output("reset ovf", 64'(ovf8), 64'd0);
        check_output("reset sum16", 64'(sum16), 64'd0);
        reset = 1'b1;

        // Known vectors
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].sub, rs, rc, rv, lat, busy_n, stable, done_after);
            check_output($sformatf("vec%0d sum", i), rs, 64'(vecs[i].sum));
            check_output($sformatf("vec%0d cout", i), 64'(rc), 64'(vecs[i].cout));
            check_output($sformatf("vec%0d ovf", i), 64'(rv), 64'(vecs[i].ovf));
            check_output($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
            check_output($sformatf("vec%0d busy cycles", i), 64'(busy_n), 64'd8);
            check_output($sformatf("vec%0d sum held while running", i), 64'(stable), 64'd1);
            check_output($sformatf("vec%0d done single pulse", i), 64'(done_after), 64'd0);
        end

        // Random 8-bit operations against the model
        for (int i = 0; i < 25; i++) begin
            av = 64'($urandom_range(0, 255));
            bv = 64'($urandom_range(0, 255));
            s = 1'($urandom);
            ref_model(8, av, bv, s, es, ec, ev);
            apply_stimulus(1'b0, av, bv, s, rs, rc, rv, lat, busy_n, stable, done_after);
            check_output($sformatf("rnd%0d sum", i), rs, es);
            check_output($sformatf("rnd%0d cout", i), 64'(rc), 64'(ec));
            check_output($sformatf("rnd%0d ovf", i), 64'(rv), 64'(ev));
            check_output($sformatf("rnd%0d latency", i), 64'(lat), 64'd9);
        end

        // Start pulsed three cycles into RUN must be ignored
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'hCC; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dn = 0; first_sum = '0; first_cout = 1'b0;
        repeat (24) begin
            if (done8) begin
                dn++;
                if (dn == 1) begin first_sum = sum8; first_cout = cout8; end
            end
            @(negedge clk);
        end
        check_output("ignored start done count", 64'(dn), 64'd1);
        check_output("ignored start sum", 64'(first_sum), 64'h76);
        check_output("ignored start cout", 64'(first_cout), 64'd1);
        check_output("ignored start idle after", 64'(busy8), 64'd0);

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'hCC; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("abort busy", 64'(busy8), 64'd0);
        check_output("abort done", 64'(done8), 64'd0);
        check_output("abort sum", 64'(sum8), 64'd0);
        check_output("abort cout", 64'(cout8), 64'd0);
        check_output("abort ovf", 64'(ovf8), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dn++;
        end
        check_output("abort no done", 64'(dn), 64'd0);
        apply_stimulus(1'b0, 64'hAA, 64'hCC, 1'b0, rs, rc, rv, lat, busy_n, stable, done_after);
        check_output("restart sum", rs, 64'h76);
        check_output("restart ovf", 64'(rv), 64'd1);
        check_output("restart latency", 64'(lat), 64'd9);

        // Start held high: one result every 9 cycles, sum steady between pulses
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        since = -1; pulses = 0; bad_gap = 0; bad_sum = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                if (since >= 0 && since + 1 != 9) bad_gap++;
                if (sum8 !== 8'h02) bad_sum++;
                since = 0;
            end else if (since >= 0) begin
                since++;
                if (sum8 !== 8'h02) bad_sum++;
            end
        end
        start8 = 1'b0;
        check_output("held start pulses", 64'(pulses), 64'd4);
        check_output("held start bad gaps", 64'(bad_gap), 64'd0);
        check_output("held start sum unstable", 64'(bad_sum), 64'd0);
        repeat (12) @(negedge clk);

        // WIDTH=16 corner and random operations
        apply_stimulus(1'b1, 64'hFFFF, 64'h0001, 1'b0, rs, rc, rv, lat, busy_n, stable, done_after);
        check_output("w16 sum", rs, 64'h0000);
        check_output("w16 cout", 64'(rc), 64'd1);
        check_output("w16 ovf", 64'(rv), 64'd0);
        check_output("w16 latency", 64'(lat), 64'd17);
        check_output("w16 busy cycles", 64'(busy_n), 64'd16);
        check_output("w16 done single pulse", 64'(done_after), 64'd0);
        for (int i = 0; i < 8; i++) begin
            av = 64'($urandom_range(0, 65535));
            bv = 64'($urandom_range(0, 65535));
            s = 1'($urandom);
            ref_model(16, av, bv, s, es, ec, ev);
            apply_stimulus(1'b1, av, bv, s, rs, rc, rv, lat, busy_n, stable, done_after);
            check_output($sformatf("w16 rnd%0d sum", i), rs, es);
            check_output($sformatf("w16 rnd%0d cout", i), 64'(rc), 64'(ec));
            check_output($sformatf("w16 rnd%0d ovf", i), 64'(rv), 64'(ev));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
